gf180mcu_fd_sc_mcu9t5v0__muxn_sync: RTL and testbench

Parametrised N-way, W-bit registered multiplexer with a handshaked, blanked select change: the next generation of the 2:1 combinational mux cell. Channel switches are requested with a select/valid pair, held off for a programmable number of blanking cycles while the output is frozen, then committed atomically. It sits in clock-selection, test-mux and data-steering paths where a bare combinational mux would glitch or switch mid-word.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__muxn_pkg.sv | 21 ++
 rtl/gf180mcu_fd_sc_mcu9t5v0__muxn_sync_cnt.sv | 27 ++
 rtl/gf180mcu_fd_sc_mcu9t5v0__muxn_sync.sv | 136 +++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__muxn_sync.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__muxn_pkg.sv
// Shared types and limits for the blanked N-way registered multiplexer.
package gf180mcu_fd_sc_mcu9t5v0__muxn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLDING = 2'd1,
        COMMIT  = 2'd2
    } muxn_state_e;

    localparam int unsigned MIN_N    = 2;
    localparam int unsigned MAX_N    = 16;
    localparam int unsigned MIN_W    = 1;
    localparam int unsigned MAX_W    = 32;
    localparam int unsigned MAX_HOLD = 15;
    localparam int unsigned CNT_W    = 4;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__muxn_sync_cnt.sv
// Loadable down-counter timing the blanking interval; flags the last hold cycle.
module gf180mcu_fd_sc_mcu9t5v0__muxn_sync_cnt
    import gf180mcu_fd_sc_mcu9t5v0__muxn_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_val,
    input  logic             i_dec,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__muxn_sync.sv
// N-way W-bit registered mux; select changes are handshaked, blanked for HOLD
// cycles with the output frozen, then committed atomically.
module gf180mcu_fd_sc_mcu9t5v0__muxn_sync
    import gf180mcu_fd_sc_mcu9t5v0__muxn_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned W      = 1,
    parameter int unsigned SW     = sel_width(N),
    parameter int unsigned HOLD   = 2,
    parameter int unsigned RSTSEL = 0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [N*W-1:0] I,
    input  logic [SW-1:0] S,
    input  logic          SV,
    input  logic          EN,
    output logic [W-1:0]  Z,
    output logic [SW-1:0] SA,
    output logic          BUSY,
    output logic          REJ,
    inout  wire           VDD,
    inout  wire           VSS
);

    if (N < MIN_N || N > MAX_N) begin : g_bad_n
        $fatal(1, "N out of range");
    end
    if (W < MIN_W || W > MAX_W) begin : g_bad_w
        $fatal(1, "W out of range");
    end
    if (HOLD > MAX_HOLD) begin : g_bad_hold
        $fatal(1, "HOLD out of range");
    end
    if (RSTSEL >= N) begin : g_bad_rstsel
        $fatal(1, "RSTSEL must be below N");
    end
    if (SW != sel_width(N)) begin : g_bad_sw
        $fatal(1, "SW is derived from N and must not be overridden");
    end

    muxn_state_e   r_state;
    muxn_state_e   w_state_nxt;
    logic [SW-1:0] r_pend;
    logic [SW-1:0] r_sa;
    logic [W-1:0]  r_z;
    logic          r_busy;
    logic          r_rej;

    logic          w_s_valid;
    logic          w_accept;
    logic          w_reject;
    logic          w_dec;
    logic          w_tc;
    logic [SW-1:0] w_sel;
    logic [W-1:0]  w_chan;
    wire           w_unused_supply;

    assign w_unused_supply = VDD ^ VSS;

    assign w_s_valid = (32'(S) < N);
    assign w_accept  = (r_state == IDLE) && SV && w_s_valid && (S != r_sa);
    assign w_reject  = SV && (!w_s_valid || (r_state != IDLE));

    gf180mcu_fd_sc_mcu9t5v0__muxn_sync_cnt u_cnt (
        .i_clk  (CLK),
        .i_rst  (RST),
        .i_load (w_accept),
        .i_val  (CNT_W'(HOLD)),
        .i_dec  (w_dec),
        .o_tc   (w_tc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_dec       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (HOLD > 0) ? HOLDING : COMMIT;
                end
            end
            HOLDING: begin
                w_dec = 1'b1;
                if (w_tc) begin
                    w_state_nxt = COMMIT;
                end
            end
            COMMIT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // In the commit cycle the output already loads from the new channel.
    assign w_sel = (r_state == COMMIT) ? r_pend : r_sa;

    always_comb begin
        w_chan = '0;
        for (int k = 0; k < N; k++) begin
            if (w_sel == SW'(k)) begin
                w_chan = I[k*W +: W];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_z     <= '0;
            r_sa    <= SW'(RSTSEL);
            r_pend  <= '0;
            r_busy  <= 1'b0;
            r_rej   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rej   <= w_reject;
            if (EN && (r_state != HOLDING)) begin
                r_z <= w_chan;
            end
            if (w_accept) begin
                r_pend <= S;
                r_busy <= 1'b1;
            end
            if (r_state == COMMIT) begin
                r_sa   <= r_pend;
                r_busy <= 1'b0;
            end
        end
    end

    assign Z    = r_z;
    assign SA   = r_sa;
    assign BUSY = r_busy;
    assign REJ  = r_rej;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__muxn_sync.sv
// Scoreboard bench: three mux instances with different N/HOLD/RSTSEL share stimulus;
// a behavioural countdown model predicts every cycle and a negedge monitor compares.
module tb_gf180mcu_fd_sc_mcu9t5v0__muxn_sync;

    localparam int unsigned N_A = 4, H_A = 2, R_A = 0;
    localparam int unsigned N_B = 3, H_B = 0, R_B = 2;
    localparam int unsigned N_C = 4, H_C = 3, R_C = 1;

    typedef struct packed {
        logic [7:0] z;
        logic [1:0] sa;
        logic       busy;
        logic       rej;
    } exp_t;
    typedef exp_t [2:0] exp3_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_bus = '0;
    logic [1:0]  s = '0;
    logic        sv = 1'b0;
    logic        en = 1'b1;
    wire         vdd = 1'b1;
    wire         vss = 1'b0;

    logic [2:0][7:0] dz;
    logic [2:0][1:0] dsa;
    logic [2:0]      dbusy;
    logic [2:0]      drej;

    exp3_t sb_q[$];
    int    checks = 0;
    int    passes = 0;
    int    cyc = 0;

    // Reference model: "left" = edges remaining until the new channel takes over.
    logic [7:0] m_z    [3];
    int         m_sa   [3];
    int         m_pend [3];
    int         m_left [3];
    bit         m_rej  [3];

    always #5 clk = ~clk;

    gf180mcu_fd_sc_mcu9t5v0__muxn_sync #(.N(N_A), .W(8), .HOLD(H_A), .RSTSEL(R_A)) u_dut_a (
        .CLK(clk), .RST(rst), .I(i_bus), .S(s), .SV(sv), .EN(en),
        .Z(dz[0]), .SA(dsa[0]), .BUSY(dbusy[0]), .REJ(drej[0]), .VDD(vdd), .VSS(vss)
    );
    gf180mcu_fd_sc_mcu9t5v0__muxn_sync #(.N(N_B), .W(8), .HOLD(H_B), .RSTSEL(R_B)) u_dut_b (
        .CLK(clk), .RST(rst), .I(i_bus[23:0]), .S(s), .SV(sv), .EN(en),
        .Z(dz[1]), .SA(dsa[1]), .BUSY(dbusy[1]), .REJ(drej[1]), .VDD(vdd), .VSS(vss)
    );
    gf180mcu_fd_sc_mcu9t5v0__muxn_sync #(.N(N_C), .W(8), .HOLD(H_C), .RSTSEL(R_C)) u_dut_c (
        .CLK(clk), .RST(rst), .I(i_bus), .S(s), .SV(sv), .EN(en),
        .Z(dz[2]), .SA(dsa[2]), .BUSY(dbusy[2]), .REJ(drej[2]), .VDD(vdd), .VSS(vss)
    );

    function automatic int np(input int k);
        return (k == 0) ? N_A : (k == 1) ? N_B : N_C;
    endfunction
    function automatic int hp(input int k);
        return (k == 0) ? H_A : (k == 1) ? H_B : H_C;
    endfunction
    function automatic int rp(input int k);
        return (k == 0) ? R_A : (k == 1) ? R_B : R_C;
    endfunction

    task automatic model_step();
        exp3_t e;
        for (int k = 0; k < 3; k++) begin
            int n;
            int req;
            bit rj;
            n   = np(k);
            req = int'(s);
            if (rst) begin
                m_z[k]    = 8'h00;
                m_sa[k]   = rp(k);
                m_pend[k] = 0;
                m_left[k] = 0;
                m_rej[k]  = 1'b0;
            end else begin
                rj = sv && (req >= n || m_left[k] > 0);
                if (m_left[k] == 0) begin
                    if (en) m_z[k] = i_bus[m_sa[k]*8 +: 8];
                    if (sv && req < n && req != m_sa[k]) begin
                        m_pend[k] = req;
                        m_left[k] = hp(k) + 1;
                    end
                end else if (m_left[k] == 1) begin
                    m_sa[k] = m_pend[k];
                    if (en) m_z[k] = i_bus[m_pend[k]*8 +: 8];
                    m_left[k] = 0;
                end else begin
                    m_left[k] = m_left[k] - 1;
                end
                m_rej[k] = rj;
            end
            e[k].z    = m_z[k];
            e[k].sa   = 2'(m_sa[k]);
            e[k].busy = (m_left[k] > 0);
            e[k].rej  = m_rej[k];
        end
        sb_q.push_back(e);
    endtask

    // Present inputs, let one rising edge consume them, then model that edge.
    task automatic drive(input bit r, input bit v, input logic [1:0] sel, input bit e);
        rst = r;
        sv  = v;
        s   = sel;
        en  = e;
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic chk(input string nm, input int k, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, k, cyc, got, exp);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp3_t e;
            e = sb_q.pop_front();
            for (int k = 0; k < 3; k++) begin
                chk("Z", k, dz[k], e[k].z);
                chk("SA", k, 8'(dsa[k]), 8'(e[k].sa));
                chk("BUSY", k, 8'(dbusy[k]), 8'(e[k].busy));
                chk("REJ", k, 8'(drej[k]), 8'(e[k].rej));
            end
        end
    end

    initial begin
        i_bus = 32'h44332211;
        repeat (3) drive(1, 0, 2'd0, 1);
        repeat (2) drive(0, 0, 2'd0, 1);
        // Switch to channel 2, then disturb I[0] and poke during blanking.
        drive(0, 1, 2'd2, 1);
        i_bus[7:0] = 8'h55;
        drive(0, 1, 2'd1, 1);
        drive(0, 0, 2'd0, 1);
        drive(0, 1, 2'd3, 1);
        drive(0, 1, 2'd3, 1);
        repeat (6) drive(0, 0, 2'd0, 1);
        // Reset in the middle of a long switch.
        drive(0, 1, 2'd3, 1);
        drive(1, 0, 2'd0, 1);
        repeat (6) drive(0, 0, 2'd0, 1);
        // Back-to-back requests.
        drive(0, 1, 2'd1, 1);
        drive(0, 0, 2'd0, 1);
        drive(0, 1, 2'd2, 1);
        repeat (6) drive(0, 0, 2'd0, 1);
        // Switch with the output enable low throughout.
        drive(0, 1, 2'd0, 0);
        i_bus = 32'hdeadbeef;
        repeat (6) drive(0, 0, 2'd0, 0);
        repeat (2) drive(0, 0, 2'd0, 1);
        // Randomised traffic.
        for (int t = 0; t < 1500; t++) begin
            i_bus = $urandom;
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                  2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
        end
        drive(0, 0, 2'd0, 1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb_q.size() == 0) passes++;
        else $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
